// File: rtl/lif_neuron_array.sv
// Array of leaky integrate-and-fire neurons sharing one update datapath.
// Each accepted update leaks the target membrane toward V_REST, adds the input
// current with saturation, fires against V_TH and queues the spiking index in
// a small event FIFO. State is written on the accepting edge, so back-to-back
// updates of the same neuron see each other without any forwarding path.
// Optional feature: define LIF_ARRAY_SPIKE_COUNT_EN to add per-neuron 16-bit
// saturating spike counters readable through cnt_idx/cnt_val.
module lif_neuron_array #(
  parameter int N_NEURONS      = 8,
  parameter int W              = 16,
  parameter int Q              = 12,
  parameter int V_TH           = 1 << Q,
  parameter int V_RESET        = 0,
  parameter int V_REST         = 0,
  parameter int LEAK_A         = 3931,  // 0.96 in Q4.12 (0x0F5B)
  parameter int REFR_TICKS     = 0,
  parameter int SPK_FIFO_DEPTH = 4,
  localparam int IW            = $clog2(N_NEURONS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IW-1:0]       in_idx,
  input  logic signed [W-1:0] in_current,
  output logic                spk_valid,
  input  logic                spk_ready,
  output logic [IW-1:0]       spk_idx,
  output logic                upd_valid,
  output logic [IW-1:0]       upd_idx,
  output logic signed [W-1:0] upd_v
`ifdef LIF_ARRAY_SPIKE_COUNT_EN
  ,
  input  logic [IW-1:0]       cnt_idx,
  output logic [15:0]         cnt_val
`endif
);

  localparam int RW = (REFR_TICKS > 0) ? $clog2(REFR_TICKS + 1) : 1;
  localparam int PW = $clog2(SPK_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int XW = 2 * W + 2;

  localparam logic signed [W-1:0] VTH_C    = W'(V_TH);
  localparam logic signed [W-1:0] VRESET_C = W'(V_RESET);
  localparam logic signed [W-1:0] VREST_C  = W'(V_REST);
  localparam logic signed [W-1:0] LEAK_C   = W'(LEAK_A);
  localparam logic signed [W-1:0] VMAX_C   = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] VMIN_C   = {1'b1, {(W-1){1'b0}}};

  // Clamp a wide signed sum into the W-bit membrane range.
  function automatic logic signed [W-1:0] sat_w(input logic signed [XW-1:0] x);
    logic signed [XW-1:0] hi;
    logic signed [XW-1:0] lo;
    hi = XW'(VMAX_C);
    lo = XW'(VMIN_C);
    if (x > hi)      sat_w = VMAX_C;
    else if (x < lo) sat_w = VMIN_C;
    else             sat_w = x[W-1:0];
  endfunction

  // Exponential decay toward the resting potential; the shift floors.
  function automatic logic signed [XW-1:0] leak_w(input logic signed [W-1:0] v);
    logic signed [W:0]   diff;
    logic signed [2*W:0] prod;
    diff   = (W+1)'(v) - (W+1)'(VREST_C);
    prod   = (2*W+1)'(LEAK_C) * (2*W+1)'(diff);
    leak_w = XW'(prod >>> Q) + XW'(VREST_C);
  endfunction

  logic signed [W-1:0]  v_q    [N_NEURONS];
  logic [RW-1:0]        refr_q [N_NEURONS];
  logic [IW-1:0]        fifo_q [SPK_FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 upd_valid_q;
  logic [IW-1:0]        upd_idx_q;
  logic signed [W-1:0]  upd_v_q;

  logic                 idx_ok, acc, push, pop, spike;
  logic [IW-1:0]        rd_idx;
  logic signed [W-1:0]  v_cur, vn, v_wr;
  logic [RW-1:0]        refr_cur, refr_wr;

  assign idx_ok    = (32'(in_idx) < N_NEURONS);
  assign in_ready  = ~rst & (cnt_q < CW'(SPK_FIFO_DEPTH));
  assign acc       = in_valid & in_ready;
  assign spk_valid = ~rst & (cnt_q != '0);
  assign spk_idx   = spk_valid ? fifo_q[rd_ptr_q] : '0;
  assign pop       = spk_valid & spk_ready;
  assign push      = acc & idx_ok & spike;

  assign upd_valid = upd_valid_q;
  assign upd_idx   = upd_idx_q;
  assign upd_v     = upd_v_q;

  // Neuron update: leak, integrate, then refractory / fire / hold decision.
  always_comb begin
    rd_idx   = idx_ok ? in_idx : '0;
    v_cur    = v_q[rd_idx];
    refr_cur = refr_q[rd_idx];
    vn       = sat_w(leak_w(v_cur) + XW'(in_current));
    spike    = 1'b0;
    v_wr     = vn;
    refr_wr  = refr_cur;
    if (refr_cur != '0) begin
      v_wr    = VRESET_C;
      refr_wr = refr_cur - RW'(1);
    end else if (vn >= VTH_C) begin
      v_wr    = VRESET_C;
      refr_wr = RW'(REFR_TICKS);
      spike   = 1'b1;
    end
  end

  // Write back the membrane and refractory state of the accepted neuron.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i]    <= VRESET_C;
        refr_q[i] <= '0;
      end
    end else if (acc && idx_ok) begin
      v_q[rd_idx]    <= v_wr;
      refr_q[rd_idx] <= refr_wr;
    end
  end

  // Spike FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Spike FIFO control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Spike FIFO storage; head is masked on the output when empty.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= in_idx;
  end

  // One-cycle monitor strobe carrying the value written for the update.
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_valid_q <= 1'b0;
      upd_idx_q   <= '0;
      upd_v_q     <= '0;
    end else begin
      upd_valid_q <= acc;
      if (acc) begin
        upd_idx_q <= in_idx;
        upd_v_q   <= idx_ok ? v_wr : '0;
      end
    end
  end

`ifdef LIF_ARRAY_SPIKE_COUNT_EN
  logic [15:0]   spk_cnt_q [N_NEURONS];
  logic [IW-1:0] cnt_rd;

  assign cnt_rd  = (32'(cnt_idx) < N_NEURONS) ? cnt_idx : '0;
  assign cnt_val = (32'(cnt_idx) < N_NEURONS) ? spk_cnt_q[cnt_rd] : 16'd0;

  // Per-neuron spike counters, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_NEURONS; i++) spk_cnt_q[i] <= 16'd0;
    end else if (push && (spk_cnt_q[rd_idx] != 16'hFFFF)) begin
      spk_cnt_q[rd_idx] <= spk_cnt_q[rd_idx] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lif_neuron_array.sv
// Scoreboard bench for lif_neuron_array: stimulus pushes expected monitor
// strobes and spike events into queues, an independent monitor pops them.
// The array is built with 6 neurons so indices 6 and 7 are out of range.
module tb_lif_neuron_array;
  localparam int N      = 6;
  localparam int W      = 16;
  localparam int Q      = 12;
  localparam int VTH    = 4096;
  localparam int VRESET = 0;
  localparam int VREST  = 0;
  localparam int LEAK   = 3931;
  localparam int REFR   = 2;
  localparam int DEPTH  = 4;
  localparam int IW     = 3;

  typedef struct {
    int idx;
    int v;
  } upd_t;

  logic                clk = 1'b0;
  logic                rst, in_valid, in_ready, spk_valid, spk_ready, upd_valid;
  logic [IW-1:0]       in_idx, spk_idx, upd_idx;
  logic signed [W-1:0] in_current, upd_v;
`ifdef LIF_ARRAY_SPIKE_COUNT_EN
  logic [IW-1:0]       cnt_idx;
  logic [15:0]         cnt_val;
  int                  mc [N];
`endif

  upd_t exp_upd [$];
  int   exp_spk [$];
  int   checks = 0;
  int   errors = 0;
  int   mv [N];
  int   mr [N];
  bit   rnd_ready = 1'b0;
  bit   spk_force = 1'b0;

  always #5 clk = ~clk;

  lif_neuron_array #(
    .N_NEURONS(N), .W(W), .Q(Q), .V_TH(VTH), .V_RESET(VRESET), .V_REST(VREST),
    .LEAK_A(LEAK), .REFR_TICKS(REFR), .SPK_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_idx(in_idx), .in_current(in_current), .spk_valid(spk_valid),
    .spk_ready(spk_ready), .spk_idx(spk_idx), .upd_valid(upd_valid),
    .upd_idx(upd_idx), .upd_v(upd_v)
`ifdef LIF_ARRAY_SPIKE_COUNT_EN
    , .cnt_idx(cnt_idx), .cnt_val(cnt_val)
`endif
  );

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference neuron: real-valued rules evaluated with wide integers.
  function automatic void model_step(input int idx, input int cur, output int nv, output bit spk);
    longint leak, sum;
    spk = 1'b0;
    nv  = 0;
    if (idx >= N) return;
    leak = VREST + ((longint'(LEAK) * (longint'(mv[idx]) - VREST)) >>> Q);
    sum  = leak + cur;
    if (sum > 32767)  sum = 32767;
    if (sum < -32768) sum = -32768;
    if (mr[idx] != 0) begin
      mr[idx] = mr[idx] - 1;
      nv = VRESET;
    end else if (sum >= VTH) begin
      nv = VRESET;
      mr[idx] = REFR;
      spk = 1'b1;
    end else begin
      nv = int'(sum);
    end
    mv[idx] = nv;
  endfunction

  // Monitor: consumes expected strobes and spike events as the DUT shows them.
  always @(negedge clk) begin : monitor
    upd_t e;
    int   s;
    if (!rst) begin
      if (upd_valid) begin
        if (exp_upd.size() == 0) chk("upd_unexpected", 1, 0);
        else begin
          e = exp_upd.pop_front();
          chk("upd_idx", upd_idx, e.idx);
          chk("upd_v", upd_v, e.v);
        end
      end
      if (spk_valid && spk_ready) begin
        if (exp_spk.size() == 0) chk("spk_unexpected", 1, 0);
        else begin
          s = exp_spk.pop_front();
          chk("spk_idx", spk_idx, s);
        end
      end
    end
  end

  // Consumer side: forced value or random backpressure, changed after each edge.
  initial begin
    spk_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      spk_ready = rnd_ready ? 1'($urandom % 2) : spk_force;
    end
  end

  // Issue one update; called and returning at 1 time unit after a rising edge.
  task automatic send(input int idx, input int cur, input bit fix = 1'b0, input int fix_v = 0);
    int   nv;
    bit   spk;
    upd_t e;
    int   w;
    in_valid   = 1'b1;
    in_idx     = IW'(idx);
    in_current = W'(cur);
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      return;
    end
    model_step(idx, cur, nv, spk);
    e.idx = idx;
    e.v   = fix ? fix_v : nv;
    exp_upd.push_back(e);
    if (spk) begin
      exp_spk.push_back(idx);
`ifdef LIF_ARRAY_SPIKE_COUNT_EN
      if (mc[idx] < 65535) mc[idx]++;
`endif
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    exp_upd.delete();
    exp_spk.delete();
    for (int i = 0; i < N; i++) begin
      mv[i] = VRESET;
      mr[i] = 0;
`ifdef LIF_ARRAY_SPIKE_COUNT_EN
      mc[i] = 0;
`endif
    end
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_spk_valid", spk_valid, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_spk_valid", spk_valid, 0);
    chk("post_rst_upd_valid", upd_valid, 0);
    chk("post_rst_upd_v", upd_v, 0);
    chk("post_rst_upd_idx", upd_idx, 0);
    chk("post_rst_spk_idx", spk_idx, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    spk_force = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (exp_spk.size() == 0 && exp_upd.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain_spk_left", exp_spk.size(), 0);
    chk("drain_upd_left", exp_upd.size(), 0);
    spk_force = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

`ifdef LIF_ARRAY_SPIKE_COUNT_EN
  task automatic check_counts();
    for (int i = 0; i < 8; i++) begin
      cnt_idx = IW'(i);
      #1;
      chk("cnt_val", cnt_val, (i < N) ? mc[i] : 0);
    end
  endtask
`endif

  initial begin
    int cur;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_idx     = '0;
    in_current = '0;
`ifdef LIF_ARRAY_SPIKE_COUNT_EN
    cnt_idx    = '0;
`endif
    @(posedge clk);
    #1;
    do_reset();

    // Integrate to spike on neuron 3.
    send(3, 'h0800, 1'b1, 'h0800);
    chk("its_no_spike_1", spk_valid, 0);
    send(3, 'h0800, 1'b1, 'h0FAD);
    chk("its_no_spike_2", spk_valid, 0);
    send(3, 'h0800, 1'b1, 0);
    chk("its_spk_valid", spk_valid, 1);
    chk("its_spk_idx", spk_idx, 3);
    drain();

    // Same-index back-to-back and out-of-range indices.
    send(5, 'h0400, 1'b1, 'h0400);
    send(5, 'h0400, 1'b1, 'h07D6);
    send(7, 'h7FFF, 1'b1, 0);
    chk("oob_no_spike", spk_valid, 0);
    send(6, 'h7FFF, 1'b1, 0);
    send(5, 0, 1'b1, 'h0785);
    drain();

    // Saturation toward the negative rail.
    do_reset();
    send(0, -32768, 1'b1, -32768);
    send(0, -32768, 1'b1, -32768);
    drain();

    // Refractory window with continuous consumer.
    spk_force = 1'b1;
    @(posedge clk);
    #1;
    send(1, 'h7FFF, 1'b1, 0);
    chk("refr_first_spike", spk_valid, 1);
    send(1, 'h7FFF, 1'b1, 0);
    chk("refr_quiet_1", spk_valid, 0);
    send(1, 'h7FFF, 1'b1, 0);
    chk("refr_quiet_2", spk_valid, 0);
    send(1, 'h7FFF, 1'b1, 0);
    chk("refr_spike_again", spk_valid, 1);
    chk("refr_spike_idx", spk_idx, 1);
    drain();

    // Backpressure: fill the FIFO, then release exactly one event.
    do_reset();
    for (int i = 0; i < 4; i++) send(i, 'h7FFF);
    chk("bp_full_in_ready", in_ready, 0);
    chk("bp_head", spk_idx, 0);
    spk_force = 1'b1;
    @(negedge clk);
    chk("bp_pop_cycle_in_ready", in_ready, 0);
    spk_force = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_after_pop_in_ready", in_ready, 1);
    chk("bp_new_head", spk_idx, 1);
    send(5, 'h7FFF);
    drain();

    // Reset with three events queued.
    do_reset();
    for (int i = 0; i < 3; i++) send(i, 'h7FFF);
    chk("mid_queued", spk_valid, 1);
`ifdef LIF_ARRAY_SPIKE_COUNT_EN
    check_counts();
`endif
    do_reset();
`ifdef LIF_ARRAY_SPIKE_COUNT_EN
    check_counts();
`endif
    for (int i = 0; i < N; i++) send(i, 0, 1'b1, VRESET);
    drain();

    // Randomized traffic with random consumer backpressure.
    rnd_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom % 4 == 0) cur = int'($signed(16'($urandom)));
      else                   cur = int'($urandom_range(0, 'h0C00));
      send(int'($urandom_range(0, 7)), cur);
      if ($urandom % 5 == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_ready = 1'b0;
    drain();
`ifdef LIF_ARRAY_SPIKE_COUNT_EN
    check_counts();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
